// File: rtl/genome_loader.sv
// Framed byte-stream loader: sync byte, two bytes per logic element, optional XOR checksum
// (GENOME_CHECKSUM_EN); assembled in a shadow bank and committed atomically to the conf buses.
module genome_loader #(
    parameter int         NUM_LE     = 16,
    parameter int         NUM_INPUTS = 26,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [3*NUM_LE-1:0]   conf_func_all,
    output logic [10*NUM_LE-1:0]  conf_ins_all,
    output logic                  load_done,
    output logic                  load_error,
    output logic                  busy
);

    localparam int               CNT_W     = $clog2(2*NUM_LE);
    localparam int               IDX_W     = CNT_W - 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(2*NUM_LE-1);
    localparam logic [5:0]       IDX_LIMIT = 6'(NUM_INPUTS);

`ifdef GENOME_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_COMMIT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;
`endif

    state_t                 state_reg;
    logic [CNT_W-1:0]       byte_cnt_reg;
    logic                   range_err_reg;
`ifdef GENOME_CHECKSUM_EN
    logic [7:0]             xor_reg;
`endif
    logic [2:0]             shadow_func_reg [NUM_LE];
    logic [9:0]             shadow_ins_reg  [NUM_LE];
    logic [3*NUM_LE-1:0]    shadow_func_flat;
    logic [10*NUM_LE-1:0]   shadow_ins_flat;
    logic [3*NUM_LE-1:0]    conf_func_reg;
    logic [10*NUM_LE-1:0]   conf_ins_reg;
    logic                   load_done_reg;
    logic                   load_error_reg;

    logic                   accept;
    logic [IDX_W-1:0]       elem_idx;
    logic [4:0]             idx_lo;
    logic [4:0]             idx_hi;
    logic                   range_bad;

    assign in_ready      = (state_reg != S_COMMIT);
    assign busy          = (state_reg != S_IDLE);
    assign accept        = in_valid && in_ready;
    assign conf_func_all = conf_func_reg;
    assign conf_ins_all  = conf_ins_reg;
    assign load_done     = load_done_reg;
    assign load_error    = load_error_reg;

    // Byte 1 completes the upper index from the stored byte 0 plus the incoming low two bits.
    assign elem_idx  = byte_cnt_reg[CNT_W-1:1];
    assign idx_lo    = shadow_ins_reg[elem_idx][4:0];
    assign idx_hi    = {in_data[1:0], shadow_ins_reg[elem_idx][7:5]};
    assign range_bad = ({1'b0, idx_lo} >= IDX_LIMIT) || ({1'b0, idx_hi} >= IDX_LIMIT);

    generate
        for (genvar gi = 0; gi < NUM_LE; gi++) begin : g_pack
            assign shadow_func_flat[3*gi +: 3]  = shadow_func_reg[gi];
            assign shadow_ins_flat[10*gi +: 10] = shadow_ins_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            byte_cnt_reg   <= '0;
            range_err_reg  <= 1'b0;
`ifdef GENOME_CHECKSUM_EN
            xor_reg        <= '0;
`endif
            for (int i = 0; i < NUM_LE; i++) begin
                shadow_func_reg[i] <= '0;
                shadow_ins_reg[i]  <= '0;
            end
            conf_func_reg  <= '0;
            conf_ins_reg   <= '0;
            load_done_reg  <= 1'b0;
            load_error_reg <= 1'b0;
        end else begin
            load_done_reg  <= 1'b0;
            load_error_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept && in_data == SYNC_BYTE) begin
                        state_reg     <= S_LOAD;
                        byte_cnt_reg  <= '0;
                        range_err_reg <= 1'b0;
`ifdef GENOME_CHECKSUM_EN
                        xor_reg       <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        byte_cnt_reg <= byte_cnt_reg + 1'b1;
`ifdef GENOME_CHECKSUM_EN
                        xor_reg      <= xor_reg ^ in_data;
`endif
                        if (!byte_cnt_reg[0]) begin
                            shadow_ins_reg[elem_idx][7:0] <= in_data;
                        end else begin
                            shadow_ins_reg[elem_idx][9:8] <= in_data[1:0];
                            shadow_func_reg[elem_idx]     <= in_data[4:2];
                            if (range_bad) begin
                                range_err_reg <= 1'b1;
                            end
                        end
                        if (byte_cnt_reg == LAST_BYTE) begin
`ifdef GENOME_CHECKSUM_EN
                            state_reg <= S_CHECK;
`else
                            // The last byte's own range check has not reached the sticky flag yet.
                            if (range_err_reg || range_bad) begin
                                state_reg      <= S_IDLE;
                                load_error_reg <= 1'b1;
                            end else begin
                                state_reg <= S_COMMIT;
                            end
`endif
                        end
                    end
                end
`ifdef GENOME_CHECKSUM_EN
                S_CHECK: begin
                    if (accept) begin
                        if (in_data == xor_reg && !range_err_reg) begin
                            state_reg <= S_COMMIT;
                        end else begin
                            state_reg      <= S_IDLE;
                            load_error_reg <= 1'b1;
                        end
                    end
                end
`endif
                S_COMMIT: begin
                    conf_func_reg <= shadow_func_flat;
                    conf_ins_reg  <= shadow_ins_flat;
                    load_done_reg <= 1'b1;
                    state_reg     <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule
